seq_detect_scan_ctrl: RTL and testbench
=======================================

Name: seq_detect_scan_ctrl

Overview:
Controller that feeds a bit-serial Moore non-overlapping pattern detector from a parallel word stream. A job is started with a pattern and a word count. The block accepts words over a valid/ready handshake, serialises each word MSB-first into its detector sub-module, and counts matches. At job end it reports a done pulse and the final match count. It sits between a word source (bus or FIFO) and status logic that consumes match results.

Parameters:
DATA_W, 8, bits per input word, shifted MSB-first
PAT_W, 4, pattern length in bits
CNT_W, 8, width of word-count and match-count fields

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset; all state cleared while low
start  input  1  one-cycle job request; sampled only in IDLE
cfg_pattern  input  PAT_W  pattern, MSB is first bit expected; latched on accepted start
cfg_words  input  CNT_W  number of words in the job; latched on accepted start
din  input  DATA_W  input word
din_valid  input  1  din is valid
din_ready  output  1  high only in LOAD; word transfers on valid&ready at a rising edge
busy  output  1  high in every state except IDLE
hit  output  1  Moore detector output; high one cycle per match
match_count  output  CNT_W  matches in current/last job; saturates at all-ones
done  output  1  one-cycle pulse in DONE state

Behaviour:
- Reset (rst low, async): state=IDLE; din_ready=0, busy=0, hit=0, done=0, match_count=0; detector history and fill counter cleared.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE, start=1: latch cfg_pattern and cfg_words, clear match_count and detector history.
  - If cfg_words==0, go to DONE. Otherwise go to LOAD.
- IDLE, start=0: remain in IDLE.
- start outside IDLE: ignored, no effect.
- LOAD: din_ready=1. On din_valid, capture din into the shift register, set bit index to DATA_W-1, go to SHIFT. Otherwise hold; detector history is retained across stalls.
- SHIFT: present one bit per cycle, starting at index DATA_W-1, with shift_en=1 to the detector. Exactly DATA_W cycles per word.
  - After the last bit: decrement words remaining. If nonzero, go to LOAD; else go to DONE.
  - Throughput is DATA_W+1 cycles per word minimum (one LOAD bubble).
- DONE: done=1 for one cycle, then IDLE. match_count holds its value until the next accepted start.
- Detector semantics (non-overlapping):
  - History is a PAT_W-bit shift register plus a saturating fill counter (0..PAT_W), both advanced on shift_en.
  - A match occurs when the sampled bit makes fill reach PAT_W and the last PAT_W bits equal the pattern.
  - On a match, history and fill are cleared. The following bits start fresh; matched bits are never reused.
  - Detector history persists across word boundaries within a job and is cleared only by start or reset.
- Latency: the bit sampled at edge E that completes a match sets hit high for the cycle after E. match_count increments at the same edge E.
  - The final bit's match is therefore included in match_count when done asserts.
- match_count at all-ones: further matches still pulse hit but do not wrap the count.
- Reset mid-job: immediate return to IDLE; the in-flight word is discarded and no done pulse is issued.

Decomposition:
- Shared package seq_ctrl_pkg holds:
  - FSM state encoding constants: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3.
  - Default width constants.
- One sub-module, seq_pattern_detector_moore (parameter PAT_W).
  - Ports: clk, rst, clr, shift_en, bit_in, pattern, hit.
  - Contains the history register, fill counter and registered hit.
- The controller contains the FSM, word shift register, bit index, words-remaining counter and match counter.

Test Plan:
- Pattern 4'b1010, cfg_words=1, din=8'hAA -> two hit pulses (after bits 4 and 8), match_count=2, done one cycle after the last hit edge (overlapping behaviour would give 3).
- Pattern 4'b1010, din=8'b1101_0100 -> one hit after bit 5, match_count=1.
- Pattern 4'b1010, cfg_words=2, din=8'h05 then 8'h00, with din_valid held low 3 cycles between words -> one hit on the first bit of word 2 (cross-boundary), match_count=1, din_ready high during the stall.
- cfg_words=0 -> done pulses 2 cycles after the start edge, match_count=0, din_ready never high.
- start pulsed during SHIFT with a different pattern -> ignored; results reflect the original pattern.
- rst low for one cycle mid-SHIFT after one match -> all outputs 0 immediately; no done; a new job counts from 0.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial pattern-scan controller:
// FSM state encoding and default widths.
package seq_ctrl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int PAT_W_DEF  = 4;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/seq_detect_scan_ctrl_if.sv
// Job/word/status bundle between a word source and the scan controller.
// master drives jobs and words; slave is the controller.
interface seq_detect_scan_ctrl_if
   import seq_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PAT_W  = PAT_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
);

   logic              start;
   logic [PAT_W-1:0]  cfg_pattern;
   logic [CNT_W-1:0]  cfg_words;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              busy;
   logic              hit;
   logic [CNT_W-1:0]  match_count;
   logic              done;

   modport master (
      output start, cfg_pattern, cfg_words, din, din_valid,
      input  din_ready, busy, hit, match_count, done
   );

   modport slave (
      input  start, cfg_pattern, cfg_words, din, din_valid,
      output din_ready, busy, hit, match_count, done
   );

endinterface

// File: rtl/seq_pattern_detector_moore.sv
// Bit-serial Moore detector, non-overlapping. History and fill advance on
// shift_en; a full window equal to the pattern raises hit next cycle and
// restarts the search from empty. match is the same-edge combinational view.
module seq_pattern_detector_moore #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   output logic             match,
   output logic             hit
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0]  hist, hist_nxt;
   logic [FILL_W-1:0] fill, fill_nxt;

   // Window after taking the current bit; fill saturates at PAT_W.
   always_comb begin
      hist_nxt = PAT_W'({hist, bit_in});
      fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
      match    = shift_en && (fill_nxt == FILL_W'(PAT_W)) && (hist_nxt == pattern);
   end

   // History/fill update; a match empties the window so bits are never reused.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '0;
         fill <= '0;
         hit  <= 1'b0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
         hit  <= 1'b0;
      end else if (shift_en) begin
         if (match) begin
            hist <= '0;
            fill <= '0;
            hit  <= 1'b1;
         end else begin
            hist <= hist_nxt;
            fill <= fill_nxt;
            hit  <= 1'b0;
         end
      end else begin
         hit <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_detect_scan_ctrl.sv
// Scan controller: takes a job (pattern, word count), pulls words over
// valid/ready, shifts each MSB-first into the detector and counts matches.
// done is a registered decode of the DONE state, so it trails the final
// hit by one cycle with match_count already final.
module seq_detect_scan_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PAT_W  = PAT_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_detect_scan_ctrl_if.slave bus
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t            state;
   logic [DATA_W-1:0] word_q;
   logic [IDX_W-1:0]  bit_idx;
   logic [CNT_W-1:0]  words_left;
   logic [CNT_W-1:0]  match_cnt;
   logic [PAT_W-1:0]  pat_q;
   logic              ready_q;
   logic              busy_q;
   logic              done_q;

   logic start_acc;
   logic shift_en;
   logic bit_cur;
   logic det_match;
   logic det_hit;

   assign start_acc = (state == IDLE) && bus.start;
   assign shift_en  = (state == SHIFT);
   assign bit_cur   = word_q[bit_idx];

   seq_pattern_detector_moore #(.PAT_W(PAT_W)) u_det (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_acc),
      .shift_en (shift_en),
      .bit_in   (bit_cur),
      .pattern  (pat_q),
      .match    (det_match),
      .hit      (det_hit)
   );

   // Job FSM with registered outputs; din_ready/busy are set with the
   // transition so they line up exactly with LOAD / non-IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         word_q     <= '0;
         bit_idx    <= '0;
         words_left <= '0;
         match_cnt  <= '0;
         pat_q      <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= (state == DONE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  pat_q      <= bus.cfg_pattern;
                  words_left <= bus.cfg_words;
                  match_cnt  <= '0;
                  busy_q     <= 1'b1;
                  if (bus.cfg_words == '0) begin
                     state <= DONE;
                  end else begin
                     state   <= LOAD;
                     ready_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (bus.din_valid) begin
                  word_q  <= bus.din;
                  bit_idx <= IDX_W'(DATA_W - 1);
                  ready_q <= 1'b0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (det_match && (match_cnt != '1))
                  match_cnt <= match_cnt + 1'b1;
               if (bit_idx == '0) begin
                  words_left <= words_left - 1'b1;
                  if (words_left == CNT_W'(1)) begin
                     state <= DONE;
                  end else begin
                     state   <= LOAD;
                     ready_q <= 1'b1;
                  end
               end else begin
                  bit_idx <= bit_idx - 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.din_ready   = ready_q;
   assign bus.busy        = busy_q;
   assign bus.hit         = det_hit;
   assign bus.match_count = match_cnt;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_detect_scan_ctrl.sv
// Scoreboard bench for seq_detect_scan_ctrl: each job pushes its expected
// result; a negedge monitor pops and checks on every done pulse.
module tb_seq_detect_scan_ctrl;
   import seq_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   seq_detect_scan_ctrl_if #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) sif ();

   seq_detect_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (sif)
   );

   // gap: 0 = no timing check, 1 = done one cycle after last hit,
   //      2 = done two cycles after the start cycle
   typedef struct {
      int cnt;
      int hits;
      int ready_cyc;
      int gap;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests   = 0;
   int   n_fail    = 0;
   int   cyc       = 0;
   int   start_cyc = 0;
   int   done_cnt  = 0;
   int   hits_seen = 0;
   int   ready_seen = 0;
   int   last_hit  = 0;

   // Cycle counter used for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: reset-state checks while reset is low; per-job checks on done.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_din_ready",   int'(sif.din_ready),   0);
         chk("rst_busy",        int'(sif.busy),        0);
         chk("rst_hit",         int'(sif.hit),         0);
         chk("rst_done",        int'(sif.done),        0);
         chk("rst_match_count", int'(sif.match_count), 0);
         hits_seen  = 0;
         ready_seen = 0;
      end else begin
         if (sif.hit) begin
            hits_seen++;
            last_hit = cyc;
         end
         if (sif.din_ready) ready_seen++;
         if (sif.done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", int'(sif.done), 0);
            end else begin
               mon_e = sb.pop_front();
               chk("match_count",  int'(sif.match_count), mon_e.cnt);
               chk("hit_pulses",   hits_seen,  mon_e.hits);
               chk("ready_cycles", ready_seen, mon_e.ready_cyc);
               if (mon_e.gap == 1)
                  chk("done_after_last_hit", cyc - last_hit, 1);
               else if (mon_e.gap == 2)
                  chk("done_after_start", cyc - start_cyc, 2);
            end
            done_cnt++;
            hits_seen  = 0;
            ready_seen = 0;
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!sif.din_ready) begin
         @(negedge clk);
         t++;
         if (t > 200) begin
            $display("FAIL din_ready_timeout: din_ready low for %0d cycles, required high", t);
            $fatal(1);
         end
      end
   endtask

   task automatic wait_done(input int d0);
      int t = 0;
      while (done_cnt == d0) begin
         @(negedge clk);
         t++;
         if (t > 5000) begin
            $display("FAIL done_timeout: no done after %0d cycles, required a pulse", t);
            $fatal(1);
         end
      end
   endtask

   // One job: word 0 = w0, later words = w1; stall cycles before words >0;
   // ghost pulses a conflicting start right after word 0 is accepted.
   task automatic run_job(input logic [3:0] pat, input int nw,
                          input logic [7:0] w0, input logic [7:0] w1,
                          input int stall, input bit ghost, input bit push,
                          input int e_cnt, input int e_hits, input int e_gap);
      exp_t e;
      int   d0;
      if (push) begin
         e.cnt       = e_cnt;
         e.hits      = e_hits;
         e.ready_cyc = nw + ((nw > 0) ? stall * (nw - 1) : 0);
         e.gap       = e_gap;
         sb.push_back(e);
      end
      d0 = done_cnt;
      @(negedge clk);
      sif.start       = 1'b1;
      sif.cfg_pattern = pat;
      sif.cfg_words   = 8'(nw);
      start_cyc       = cyc;
      @(negedge clk);
      sif.start = 1'b0;
      for (int i = 0; i < nw; i++) begin
         wait_ready();
         if (i > 0) repeat (stall) @(negedge clk);
         sif.din       = (i == 0) ? w0 : w1;
         sif.din_valid = 1'b1;
         @(negedge clk);
         sif.din_valid = 1'b0;
         if (ghost && i == 0) begin
            sif.start       = 1'b1;
            sif.cfg_pattern = 4'b1111;
            sif.cfg_words   = 8'd5;
            @(negedge clk);
            sif.start = 1'b0;
         end
      end
      if (push) wait_done(d0);
   endtask

   initial begin
      int t;
      rst_n           = 1'b1;
      sif.start       = 1'b0;
      sif.cfg_pattern = '0;
      sif.cfg_words   = '0;
      sif.din         = '0;
      sif.din_valid   = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // 8'hAA, pattern 1010: non-overlapping gives 2 matches (bits 4, 8)
      run_job(4'b1010, 1, 8'hAA, 8'h00, 0, 1'b0, 1'b1, 2, 2, 1);
      // 1101_0100: single match completing on bit 5
      run_job(4'b1010, 1, 8'hD4, 8'h00, 0, 1'b0, 1'b1, 1, 1, 0);
      // 05 then 00 with 3-cycle stall: match spans the word boundary
      run_job(4'b1010, 2, 8'h05, 8'h00, 3, 1'b0, 1'b1, 1, 1, 0);
      // empty job: done two cycles after start, no din_ready
      run_job(4'b1010, 0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 0, 0, 2);
      // start during SHIFT with another pattern is ignored
      run_job(4'b1010, 1, 8'hAA, 8'h00, 0, 1'b1, 1'b1, 2, 2, 1);

      // reset mid-SHIFT while the first hit is showing; no done may follow
      run_job(4'b1010, 1, 8'hAA, 8'h00, 0, 1'b0, 1'b0, 0, 0, 0);
      t = 0;
      while (!sif.hit) begin
         @(negedge clk);
         t++;
         if (t > 50) begin
            $display("FAIL hit_timeout: no hit after %0d cycles, required one", t);
            $fatal(1);
         end
      end
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // fresh job after the reset counts from zero
      run_job(4'b1010, 1, 8'hD4, 8'h00, 0, 1'b0, 1'b1, 1, 1, 0);
      // 130 zero words, pattern 0000: 260 hits, count saturates at 255
      run_job(4'b0000, 130, 8'h00, 8'h00, 0, 1'b0, 1'b1, 255, 260, 1);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
